// File: rtl/hamming_stream_encoder_if.sv
// ----------------------------------------------------------------------------
// hamming_stream_encoder_if
//
// Streaming bus for hamming_stream_encoder: the input word handshake, the
// per-word error-injection controls, the output codeword handshake and the
// sent-word counter.
//
// Parameters:
//   DATA_W  data word width (1..64)
//   CNT_W   width of the sent-word counter
//
// Derived widths match the encoder: PAR_W parity bits, CODE_W codeword bits
// (one extra overall-parity bit when HAM_SECDED_EN is defined), and POS_W
// bits for the 1-based injection position.
//
// Modports:
//   slave   encoder side (consumes input words, produces codewords)
//   master  environment side (source framer + downstream channel)
//
// Optional feature macro: HAM_SECDED_EN
// ----------------------------------------------------------------------------
interface hamming_stream_encoder_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 16
);

    // Smallest R with 2^R >= dw + R + 1.
    function automatic int unsigned calc_par_w(input int unsigned dw);
        int unsigned r;
        r = 0;
        for (int unsigned i = 1; i <= 8; i++) begin
            if (r == 0 && (32'd1 << i) >= dw + i + 1) begin
                r = i;
            end
        end
        return r;
    endfunction

    localparam int unsigned PAR_W = calc_par_w(DATA_W);
`ifdef HAM_SECDED_EN
    localparam int unsigned CODE_W = DATA_W + PAR_W + 1;
`else
    localparam int unsigned CODE_W = DATA_W + PAR_W;
`endif
    localparam int unsigned POS_W = $clog2(CODE_W + 1);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic              inj_en;
    logic [POS_W-1:0]  inj_pos;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] code_out;
    logic [CNT_W-1:0]  word_cnt;

    modport slave (
        input  in_valid,
        output in_ready,
        input  data_in,
        input  inj_en,
        input  inj_pos,
        output out_valid,
        input  out_ready,
        output code_out,
        output word_cnt
    );

    modport master (
        output in_valid,
        input  in_ready,
        output data_in,
        output inj_en,
        output inj_pos,
        input  out_valid,
        output out_ready,
        input  code_out,
        input  word_cnt
    );

endinterface

// File: rtl/hamming_stream_encoder.sv
// ----------------------------------------------------------------------------
// hamming_stream_encoder
//
// Registered Hamming encoder with a valid/ready streaming handshake. Each
// accepted DATA_W-bit word is encoded into a CODE_W-bit codeword one clock
// later. Optionally one codeword bit is flipped per word for decoder testing.
// A counter tracks completed output transfers.
//
// Codeword layout (1-based positions, code_out[i-1] is position i):
//   powers of two hold even parity; data bits fill the rest in ascending order.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    hamming_stream_encoder_if.slave
//            in_valid/in_ready/data_in   input word handshake
//            inj_en/inj_pos              per-word single-bit flip (1-based)
//            out_valid/out_ready/code_out output codeword handshake
//            word_cnt                    completed output transfers (wraps)
//
// Optional feature macro: HAM_SECDED_EN
//   When defined, an overall even-parity bit over positions 1..DATA_W+PAR_W
//   (taken before injection) is appended as the codeword MSB.
// ----------------------------------------------------------------------------
module hamming_stream_encoder #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    hamming_stream_encoder_if.slave bus
);

    // ------------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------------
    function automatic int unsigned calc_par_w(input int unsigned dw);
        int unsigned r;
        r = 0;
        for (int unsigned i = 1; i <= 8; i++) begin
            if (r == 0 && (32'd1 << i) >= dw + i + 1) begin
                r = i;
            end
        end
        return r;
    endfunction

    localparam int unsigned PAR_W = calc_par_w(DATA_W);
    localparam int unsigned HAM_W = DATA_W + PAR_W;
`ifdef HAM_SECDED_EN
    localparam int unsigned CODE_W = HAM_W + 1;
`else
    localparam int unsigned CODE_W = HAM_W;
`endif

    if (DATA_W < 1 || DATA_W > 64) begin : g_bad_width
        $error("hamming_stream_encoder: DATA_W must be in 1..64");
    end

    // ------------------------------------------------------------------------
    // Layout helpers (evaluated on constants, unrolled by synthesis)
    // ------------------------------------------------------------------------
    function automatic logic is_pow2(input int unsigned p);
        return (p & (p - 1)) == 0;
    endfunction

    // Zero-based codeword index holding data bit bit_idx.
    function automatic int unsigned data_slot(input int unsigned bit_idx);
        int unsigned seen;
        int unsigned slot;
        seen = 0;
        slot = 0;
        for (int unsigned pos = 1; pos <= HAM_W; pos++) begin
            if (!is_pow2(pos)) begin
                if (seen == bit_idx) begin
                    slot = pos - 1;
                end
                seen++;
            end
        end
        return slot;
    endfunction

    // Data positions covered by the parity bit at position 2^k.
    function automatic logic [HAM_W-1:0] cover_mask(input int unsigned k);
        logic [HAM_W-1:0] m;
        m = '0;
        for (int unsigned pos = 1; pos <= HAM_W; pos++) begin
            if (!is_pow2(pos) && ((pos >> k) & 1) == 1) begin
                m[pos-1] = 1'b1;
            end
        end
        return m;
    endfunction

    // ------------------------------------------------------------------------
    // Encoder datapath
    // ------------------------------------------------------------------------
    logic [HAM_W-1:0]  data_placed;  // data in its slots, parity slots zero
    logic [HAM_W-1:0]  ham;
    logic [CODE_W-1:0] enc;
    logic [CODE_W-1:0] inj_mask;

    always_comb begin
        data_placed = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            data_placed[data_slot(i)] = bus.data_in[i];
        end
    end

    always_comb begin
        ham = data_placed;
        for (int unsigned k = 0; k < PAR_W; k++) begin
            ham[(32'd1 << k) - 1] = ^(data_placed & cover_mask(k));
        end
    end

`ifdef HAM_SECDED_EN
    assign enc = {^ham, ham};
`else
    assign enc = ham;
`endif

    // Position 0 and positions beyond CODE_W never match, so no flip occurs.
    always_comb begin
        inj_mask = '0;
        for (int unsigned i = 0; i < CODE_W; i++) begin
            inj_mask[i] = bus.inj_en && (32'(bus.inj_pos) == i + 1);
        end
    end

    // ------------------------------------------------------------------------
    // Handshake and output register
    // ------------------------------------------------------------------------
    logic              out_valid_d, out_valid_q;
    logic [CODE_W-1:0] code_d, code_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              in_ready;
    logic              accept;
    logic              xfer;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign xfer     = out_valid_q && bus.out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        code_d      = code_q;
        cnt_d       = cnt_q;
        // An accept in the same cycle as a drain refills the slot.
        if (accept) begin
            out_valid_d = 1'b1;
            code_d      = enc ^ inj_mask;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
        if (xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            code_q      <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            code_q      <= code_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.code_out  = code_q;
    assign bus.word_cnt  = cnt_q;

endmodule

// File: tb/tb_hamming_stream_encoder.sv
module tb_hamming_stream_encoder;

`ifdef HAM_SECDED_EN
    localparam bit SD  = 1'b1;
    localparam int CW0 = 8;
    localparam int CW1 = 16;
`else
    localparam bit SD  = 1'b0;
    localparam int CW0 = 7;
    localparam int CW1 = 15;
`endif
    localparam int IW0 = $clog2(CW0 + 1);

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hamming_stream_encoder_if #(.DATA_W(4),  .CNT_W(16)) b0 ();
    hamming_stream_encoder_if #(.DATA_W(11), .CNT_W(3))  b1 ();

    hamming_stream_encoder #(.DATA_W(4), .CNT_W(16)) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b0.slave)
    );

    hamming_stream_encoder #(.DATA_W(11), .CNT_W(3)) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b1.slave)
    );

    // Pick the hand-computed plain or SECDED codeword for the current build.
    function automatic logic [CW0-1:0] p4(input logic [6:0] plain, input logic [7:0] sec);
        logic [7:0] r;
        r = SD ? sec : {1'b0, plain};
        return r[CW0-1:0];
    endfunction

    function automatic logic [CW1-1:0] p11(input logic [14:0] plain, input logic [15:0] sec);
        logic [15:0] r;
        r = SD ? sec : {1'b0, plain};
        return r[CW1-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string          name;
        logic [3:0]     data;
        logic           inj_en;
        logic [IW0-1:0] inj_pos;
        logic [CW0-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    logic [3:0]     str_data[8];
    logic [CW0-1:0] str_exp[8];

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;

        vecs.push_back('{"enc_0010", 4'b0010, 1'b0, IW0'(0), p4(7'h19, 8'h99)});
        vecs.push_back('{"enc_1011", 4'b1011, 1'b0, IW0'(0), p4(7'h55, 8'h55)});
        vecs.push_back('{"enc_1111", 4'b1111, 1'b0, IW0'(0), p4(7'h7F, 8'hFF)});
        vecs.push_back('{"enc_0000", 4'b0000, 1'b0, IW0'(0), p4(7'h00, 8'h00)});
        vecs.push_back('{"enc_0101", 4'b0101, 1'b0, IW0'(0), p4(7'h2D, 8'h2D)});
        vecs.push_back('{"enc_1100", 4'b1100, 1'b0, IW0'(0), p4(7'h61, 8'hE1)});
        vecs.push_back('{"inj_pos3", 4'b0010, 1'b1, IW0'(3), p4(7'h1D, 8'h9D)});
        vecs.push_back('{"inj_pos0", 4'b0010, 1'b1, IW0'(0), p4(7'h19, 8'h99)});
        vecs.push_back('{"inj_pos7", 4'b0010, 1'b1, IW0'(7), p4(7'h59, 8'hD9)});
        vecs.push_back('{"inj_off",  4'b0010, 1'b0, IW0'(3), p4(7'h19, 8'h99)});
        vecs.push_back('{"inj_pos1", 4'b1111, 1'b1, IW0'(1), p4(7'h7E, 8'hFE)});
`ifdef HAM_SECDED_EN
        vecs.push_back('{"inj_pos8", 4'b0010, 1'b1, IW0'(8), 8'h19});
        vecs.push_back('{"inj_pos9", 4'b0010, 1'b1, IW0'(9), 8'h99});
`endif

        str_data = '{4'h1, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF};
        str_exp  = '{p4(7'h07, 8'h87), p4(7'h1E, 8'h1E), p4(7'h2D, 8'h2D), p4(7'h34, 8'hB4),
                     p4(7'h4C, 8'hCC), p4(7'h55, 8'h55), p4(7'h66, 8'h66), p4(7'h7F, 8'hFF)};

        // ---------------- reset ----------------
        rst_n        = 1'b0;
        b0.in_valid  = 1'b0;
        b0.data_in   = '0;
        b0.inj_en    = 1'b0;
        b0.inj_pos   = '0;
        b0.out_ready = 1'b0;
        b1.in_valid  = 1'b0;
        b1.data_in   = '0;
        b1.inj_en    = 1'b0;
        b1.inj_pos   = '0;
        b1.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", b0.out_valid, 0);
        check("rst code_out", b0.code_out, 0);
        check("rst word_cnt", b0.word_cnt, 0);
        check("rst in_ready", b0.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst in_ready", b0.in_ready, 1);

        // ---------------- table: back-to-back encodes ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            b0.in_valid  = 1'b1;
            b0.data_in   = vecs[i].data;
            b0.inj_en    = vecs[i].inj_en;
            b0.inj_pos   = vecs[i].inj_pos;
            b0.out_ready = 1'b1;
            tick();
            check({vecs[i].name, " code"}, b0.code_out, vecs[i].exp);
            check({vecs[i].name, " valid"}, b0.out_valid, 1);
            check({vecs[i].name, " cnt"}, b0.word_cnt, exp_cnt);
            exp_cnt++;
        end
        b0.in_valid = 1'b0;
        b0.inj_en   = 1'b0;
        tick();
        check("table drain valid", b0.out_valid, 0);
        check("table drain cnt", b0.word_cnt, exp_cnt);
        check("table drain hold", b0.code_out, vecs[vecs.size() - 1].exp);

        // ---------------- backpressure ----------------
        b0.in_valid  = 1'b1;
        b0.data_in   = 4'b1011;
        b0.out_ready = 1'b0;
        tick();
        check("bp load code", b0.code_out, p4(7'h55, 8'h55));
        check("bp load in_ready", b0.in_ready, 0);
        b0.data_in = 4'b1111;
        b0.inj_en  = 1'b1;  // must be ignored while stalled
        b0.inj_pos = IW0'(1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp stall code", b0.code_out, p4(7'h55, 8'h55));
            check("bp stall valid", b0.out_valid, 1);
            check("bp stall in_ready", b0.in_ready, 0);
        end
        check("bp stall cnt", b0.word_cnt, exp_cnt);
        b0.inj_en    = 1'b0;
        b0.out_ready = 1'b1;
        #1;
        check("bp release in_ready", b0.in_ready, 1);
        tick();
        exp_cnt++;
        check("bp release code", b0.code_out, p4(7'h7F, 8'hFF));
        check("bp release valid", b0.out_valid, 1);
        check("bp release cnt", b0.word_cnt, exp_cnt);
        b0.in_valid = 1'b0;
        tick();
        exp_cnt++;
        check("bp drain valid", b0.out_valid, 0);
        check("bp drain hold", b0.code_out, p4(7'h7F, 8'hFF));
        check("bp drain cnt", b0.word_cnt, exp_cnt);

        // ---------------- reset while stalled ----------------
        b0.in_valid  = 1'b1;
        b0.data_in   = 4'b0010;
        b0.out_ready = 1'b0;
        tick();
        check("stall before rst", b0.out_valid, 1);
        b0.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst valid", b0.out_valid, 0);
        check("async rst cnt", b0.word_cnt, 0);
        check("async rst code", b0.code_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;

        // ---------------- streaming: 8 words, full throughput ----------------
        b0.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b0.in_valid = 1'b1;
            b0.data_in  = str_data[i];
            tick();
            check("stream code", b0.code_out, str_exp[i]);
            check("stream valid", b0.out_valid, 1);
        end
        b0.in_valid = 1'b0;
        tick();
        check("stream cnt", b0.word_cnt, 8);
        check("stream drain valid", b0.out_valid, 0);

        // ---------------- DATA_W=11, CNT_W=3 wrap ----------------
        b1.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b1.in_valid = 1'b1;
            b1.data_in  = (i == 0) ? 11'h001 : (i == 1) ? 11'h400 : 11'h000;
            tick();
            if (i == 0) begin
                check("w11 d001", b1.code_out, p11(15'h0007, 16'h8007));
            end else if (i == 1) begin
                check("w11 d400", b1.code_out, p11(15'h408B, 16'hC08B));
            end else begin
                check("w11 d000", b1.code_out, 0);
            end
            check("w11 cnt", b1.word_cnt, i);
        end
        b1.in_valid = 1'b0;
        tick();
        check("w11 cnt wrap", b1.word_cnt, 0);
        check("w11 drain valid", b1.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
